// File: rtl/dmem_bridge_pkg.sv
// Shared types and constants for the data-memory to Avalon-MM bridge.
package dmem_bridge_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StResp,
    StDone
  } bridge_state_e;

  localparam logic [31:0] ErrReaddataDefault = 32'hDEADBEEF;

  localparam int unsigned StallCntW   = 32;
  localparam int unsigned TimeoutCntW = 16;
  localparam int unsigned TimerW      = 16;

endpackage

// File: rtl/bus_timeout_timer.sv
// Access watchdog: counts cycles spent in REQ/RESP and flags the last allowed cycle.
module bus_timeout_timer
  import dmem_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [TimerW-1:0] LastCycle = TimerW'(TIMEOUT_CYCLES - 1);

  logic [TimerW-1:0] timer_d, timer_q;

  always_comb begin
    timer_d = timer_q;
    if (clr_i) begin
      timer_d = '0;
    end else if (en_i && timer_q != '1) begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  assign expire_o = en_i && (timer_q == LastCycle);

endmodule

// File: rtl/dmem_avalon_bridge.sv
// Converts core load/store strobes into handshaked Avalon-MM accesses with a
// timeout failsafe, pipeline stall and CSR-visible stall/error counters.
module dmem_avalon_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1023,
  parameter logic [31:0] ERR_READDATA   = ErrReaddataDefault
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            core_addr,
  input  logic [31:0]            core_writedata,
  input  logic                   core_write_en,
  input  logic                   core_read_en,
  input  logic [3:0]             core_byteenable,
  output logic [31:0]            core_readdata,
  output logic                   core_stall,
  output logic [31:0]            avm_address,
  output logic                   avm_read,
  output logic                   avm_write,
  output logic [31:0]            avm_writedata,
  output logic [3:0]             avm_byteenable,
  input  logic                   avm_waitrequest,
  input  logic [31:0]            avm_readdata,
  input  logic                   avm_readdatavalid,
  output logic [StallCntW-1:0]   stall_cycles,
  output logic [TimeoutCntW-1:0] timeout_count,
  output logic                   err_sticky
);

  bridge_state_e state_d, state_q;

  logic [31:0]            addr_d, addr_q;
  logic [31:0]            wdata_d, wdata_q;
  logic [3:0]             be_d, be_q;
  logic                   is_write_d, is_write_q;
  logic [31:0]            rdata_d, rdata_q;
  logic [StallCntW-1:0]   stall_cnt_d, stall_cnt_q;
  logic [TimeoutCntW-1:0] to_cnt_d, to_cnt_q;
  logic                   err_d, err_q;
  logic                   drop_valid_d, drop_valid_q;

  logic req;
  logic valid_eff;
  logic timer_clr;
  logic timer_en;
  logic timer_expire;

  assign req       = core_read_en | core_write_en;
  // A response owed to an abandoned read must never complete a later access.
  assign valid_eff = avm_readdatavalid & ~drop_valid_q;
  assign timer_en  = (state_q == StReq) || (state_q == StResp);

  bus_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i   (clk),
    .rst_ni  (reset),
    .clr_i   (timer_clr),
    .en_i    (timer_en),
    .expire_o(timer_expire)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    is_write_d   = is_write_q;
    rdata_d      = rdata_q;
    to_cnt_d     = to_cnt_q;
    err_d        = err_q;
    drop_valid_d = drop_valid_q;
    timer_clr    = 1'b0;

    if (avm_readdatavalid && drop_valid_q) begin
      drop_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (valid_eff) begin
          err_d = 1'b1;
        end
        if (req) begin
          addr_d     = core_addr;
          wdata_d    = core_writedata;
          be_d       = core_byteenable;
          is_write_d = core_write_en;
          timer_clr  = 1'b1;
          state_d    = StReq;
          if (core_read_en && core_write_en) begin
            err_d = 1'b1;
          end
        end
      end
      StReq: begin
        if (!avm_waitrequest && (is_write_q || valid_eff)) begin
          state_d = StDone;
          if (!is_write_q) begin
            rdata_d = avm_readdata;
          end
        end else if (timer_expire) begin
          state_d = StDone;
          err_d   = 1'b1;
          if (to_cnt_q != '1) begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
          if (!is_write_q) begin
            rdata_d = ERR_READDATA;
            // Read was accepted on this last cycle, so its data is still owed.
            if (!avm_waitrequest) begin
              drop_valid_d = 1'b1;
            end
          end
        end else if (!avm_waitrequest) begin
          state_d = StResp;
        end
      end
      StResp: begin
        if (valid_eff) begin
          state_d = StDone;
          rdata_d = avm_readdata;
        end else if (timer_expire) begin
          state_d      = StDone;
          err_d        = 1'b1;
          rdata_d      = ERR_READDATA;
          drop_valid_d = 1'b1;
          if (to_cnt_q != '1) begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
        end
      end
      StDone: begin
        if (valid_eff) begin
          err_d = 1'b1;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (core_stall && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      is_write_q   <= 1'b0;
      rdata_q      <= '0;
      stall_cnt_q  <= '0;
      to_cnt_q     <= '0;
      err_q        <= 1'b0;
      drop_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      is_write_q   <= is_write_d;
      rdata_q      <= rdata_d;
      stall_cnt_q  <= stall_cnt_d;
      to_cnt_q     <= to_cnt_d;
      err_q        <= err_d;
      drop_valid_q <= drop_valid_d;
    end
  end

  // Strobes decode straight from the async-reset state so reset drops them at once.
  assign avm_read       = (state_q == StReq) && !is_write_q;
  assign avm_write      = (state_q == StReq) && is_write_q;
  assign avm_address    = addr_q;
  assign avm_writedata  = wdata_q;
  assign avm_byteenable = be_q;

  assign core_stall    = ((state_q == StIdle) && req) || timer_en;
  assign core_readdata = rdata_q;
  assign stall_cycles  = stall_cnt_q;
  assign timeout_count = to_cnt_q;
  assign err_sticky    = err_q;

endmodule

// File: tb/tb_dmem_avalon_bridge.sv
// Scoreboard bench: stimulus queues expected per-access results, a monitor checks each DONE.
module tb_dmem_avalon_bridge;

  logic        clk;
  logic        reset;
  logic [31:0] core_addr;
  logic [31:0] core_writedata;
  logic        core_write_en;
  logic        core_read_en;
  logic [3:0]  core_byteenable;
  logic [31:0] core_readdata;
  logic        core_stall;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic [31:0] stall_cycles;
  logic [15:0] timeout_count;
  logic        err_sticky;

  dmem_avalon_bridge #(
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .core_addr        (core_addr),
    .core_writedata   (core_writedata),
    .core_write_en    (core_write_en),
    .core_read_en     (core_read_en),
    .core_byteenable  (core_byteenable),
    .core_readdata    (core_readdata),
    .core_stall       (core_stall),
    .avm_address      (avm_address),
    .avm_read         (avm_read),
    .avm_write        (avm_write),
    .avm_writedata    (avm_writedata),
    .avm_byteenable   (avm_byteenable),
    .avm_waitrequest  (avm_waitrequest),
    .avm_readdata     (avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .stall_cycles     (stall_cycles),
    .timeout_count    (timeout_count),
    .err_sticky       (err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          wr_cyc;
    int          rd_cyc;
    int          stall_len;
    logic [31:0] rdata;
    logic [31:0] stall_tot;
    logic [15:0] to_cnt;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Slave model: wait_left waitrequest cycles, then read data 'delay' cycles after acceptance.
  int          wait_left = 0;
  bit          stuck = 0;
  int          delay = 0;
  bit          pending = 0;
  int          cnt = 0;
  bit          force_valid = 0;
  logic [31:0] sdata = '0;
  logic        accept;

  assign avm_waitrequest   = stuck || (wait_left > 0);
  assign accept            = (avm_read || avm_write) && !avm_waitrequest;
  assign avm_readdatavalid = force_valid || (avm_read && accept && delay == 0)
                             || (pending && cnt == 0);
  assign avm_readdata      = sdata;

  initial begin
    bit s_cmd, s_acc, s_rd;
    forever begin
      @(negedge clk);
      s_cmd = avm_read || avm_write;
      s_acc = accept;
      s_rd  = avm_read;
      @(posedge clk);
      #1;
      if (!reset) begin
        pending   = 0;
        wait_left = 0;
      end else begin
        if (s_cmd && wait_left > 0) wait_left--;
        if (s_acc && s_rd && delay > 0) begin
          pending = 1;
          cnt     = delay - 1;
        end else if (pending) begin
          if (cnt == 0) pending = 0;
          else cnt--;
        end
      end
    end
  end

  // Monitor: a falling core_stall marks DONE; compare the access just finished.
  initial begin
    int          run = 0, wr_cnt = 0, rd_cnt = 0;
    bit          prev_stall = 0, cmd_seen = 0, unstable = 0;
    logic [31:0] f_addr = '0, f_wd = '0;
    logic [3:0]  f_be = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        run = 0; wr_cnt = 0; rd_cnt = 0; prev_stall = 0; cmd_seen = 0; unstable = 0;
        continue;
      end
      if (avm_write) wr_cnt++;
      if (avm_read) rd_cnt++;
      if (avm_read || avm_write) begin
        if (!cmd_seen) begin
          cmd_seen = 1;
          f_addr   = avm_address;
          f_wd     = avm_writedata;
          f_be     = avm_byteenable;
        end else if (avm_address !== f_addr || avm_writedata !== f_wd
                     || avm_byteenable !== f_be) begin
          unstable = 1;
        end
      end
      if (core_stall) begin
        run++;
      end else if (prev_stall) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=completion expected=none");
        end else begin
          e = exp_q.pop_front();
          chk("avm_address", f_addr, e.addr);
          chk("cmd_stable", 32'(unstable), 32'd0);
          chk("avm_write_cycles", 32'(wr_cnt), 32'(e.wr_cyc));
          chk("avm_read_cycles", 32'(rd_cnt), 32'(e.rd_cyc));
          chk("stall_len", 32'(run), 32'(e.stall_len));
          chk("core_readdata", core_readdata, e.rdata);
          chk("stall_cycles", stall_cycles, e.stall_tot);
          chk("timeout_count", 32'(timeout_count), 32'(e.to_cnt));
          chk("err_sticky", 32'(err_sticky), 32'(e.err));
        end
        run = 0; wr_cnt = 0; rd_cnt = 0; cmd_seen = 0; unstable = 0;
      end
      prev_stall = core_stall;
    end
  end

  task automatic access(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                        input logic we, input logic re, input int wt, input bit stk,
                        input int dly, input logic [31:0] sd, input exp_t e);
    bit seen = 0;
    bit done = 0;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
    wait_left       = wt;
    stuck           = stk;
    delay           = dly;
    sdata           = sd;
    core_addr       = a;
    core_writedata  = wd;
    core_byteenable = be;
    core_write_en   = we;
    core_read_en    = re;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (core_stall) seen = 1;
      else if (seen) done = 1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL access_timeout actual=no_done expected=done addr=%h", a);
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #2;
    core_write_en = 1'b0;
    core_read_en  = 1'b0;
    stuck         = 0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_avm_read"}, 32'(avm_read), 32'd0);
    chk({tag, "_avm_write"}, 32'(avm_write), 32'd0);
    chk({tag, "_core_stall"}, 32'(core_stall), 32'd0);
    chk({tag, "_stall_cycles"}, stall_cycles, 32'd0);
    chk({tag, "_timeout_count"}, 32'(timeout_count), 32'd0);
    chk({tag, "_err_sticky"}, 32'(err_sticky), 32'd0);
    chk({tag, "_core_readdata"}, core_readdata, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset           = 1'b0;
    core_addr       = '0;
    core_writedata  = '0;
    core_write_en   = 1'b0;
    core_read_en    = 1'b0;
    core_byteenable = '0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    @(negedge clk);
    reset_checks("por");

    // Zero-wait write.
    access(32'h100, 32'hA5A5A5A5, 4'hF, 1, 0, 0, 0, 0, 32'h0,
           '{32'h100, 1, 0, 2, 32'h0, 32'd2, 16'd0, 1'b0});
    idle();

    // Read: 3 waitrequest cycles, data 2 cycles after acceptance.
    access(32'h104, 32'h0, 4'hF, 0, 1, 3, 0, 2, 32'h12345678,
           '{32'h104, 0, 4, 7, 32'h12345678, 32'd9, 16'd0, 1'b0});
    idle();

    // Back-to-back store then load with requests held through DONE.
    access(32'h200, 32'h55AA55AA, 4'h3, 1, 0, 0, 0, 0, 32'h0,
           '{32'h200, 1, 0, 2, 32'h12345678, 32'd11, 16'd0, 1'b0});
    access(32'h204, 32'h0, 4'hF, 0, 1, 0, 0, 0, 32'h0BADF00D,
           '{32'h204, 0, 1, 2, 32'h0BADF00D, 32'd13, 16'd0, 1'b0});
    idle();

    // Timeout with waitrequest stuck high.
    access(32'h80, 32'h0, 4'hF, 0, 1, 0, 1, 0, 32'h0,
           '{32'h80, 0, 8, 9, 32'hDEADBEEF, 32'd22, 16'd1, 1'b1});
    idle();

    // Late readdatavalid after the timeout must not reach the core.
    @(posedge clk);
    #2;
    sdata       = 32'h11111111;
    force_valid = 1;
    @(posedge clk);
    #2;
    force_valid = 0;
    @(negedge clk);
    chk("late_valid_readdata", core_readdata, 32'hDEADBEEF);
    chk("late_valid_stall", 32'(core_stall), 32'd0);
    chk("late_valid_err", 32'(err_sticky), 32'd1);

    // Async reset in REQ: strobe must drop before any clock edge.
    @(posedge clk);
    #2;
    stuck        = 1;
    core_addr    = 32'h400;
    core_read_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("req_avm_read", 32'(avm_read), 32'd1);
    #1;
    reset        = 1'b0;
    core_read_en = 1'b0;
    #1;
    reset_checks("rst_req");
    repeat (2) @(posedge clk);
    #2;
    stuck = 0;
    reset = 1'b1;

    // Async reset in RESP.
    @(posedge clk);
    #2;
    delay        = 6;
    core_addr    = 32'h500;
    core_read_en = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    reset        = 1'b0;
    core_read_en = 1'b0;
    #1;
    reset_checks("rst_resp");
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_stall", 32'(core_stall), 32'd0);

    // Read and write strobes together: one write, error flagged.
    access(32'h300, 32'hCAFEF00D, 4'hF, 1, 1, 0, 0, 0, 32'h0,
           '{32'h300, 1, 0, 2, 32'h0, 32'd2, 16'd0, 1'b1});
    idle();

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
